// File: rtl/zeus_bus_pkg.sv
// Shared types and constants for the CPU-side Wishbone initiator.
package zeus_bus_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 8;

    // Read data returned to the CPU when a transaction times out
    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } wb_state_e;

    // 65C816 cycle-type tags carried alongside the address
    typedef struct packed {
        logic vp;
        logic vpa;
        logic vda;
    } cpu_tag_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog for the ack wait: counts WAIT_ACK cycles without ack.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic hit,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on WAIT_ACK entry, advance on each unacked cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !hit && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Current cycle is the last allowed unacked WAIT_ACK cycle
    assign expired = enable && !hit && (cnt_q == LAST);

endmodule

// File: rtl/cpu_wb_initiator.sv
// CPU request -> single-beat pipelined Wishbone initiator.
// Optional ack watchdog enabled by defining CPU_WB_TIMEOUT_EN.
module cpu_wb_initiator
    import zeus_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_we_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_vp_i,
    input  logic              cpu_vpa_i,
    input  logic              cpu_vda_i,
    output logic              cpu_busy_o,
    output logic              cpu_done_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_abort_o,
    output logic              cpu_buserr_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_write_o,
    output logic              wb_cyc_o,
    output logic              wb_strobe_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack_i,
    input  logic              wb_stall_i,
    output logic              wb_vp_o,
    output logic              wb_vpa_o,
    output logic              wb_vda_o,
    input  logic              access_violation_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    wb_state_e         state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    cpu_tag_t          tag_q, tag_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              abort_q, abort_d;
    logic              buserr_q, buserr_d;

`ifdef CPU_WB_TIMEOUT_EN
    logic tmo_clear_c;
    logic tmo_expired_c;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_reset_i),
        .clear   (tmo_clear_c),
        .enable  (state_q == WAIT_ACK),
        .hit     (wb_ack_i),
        .expired (tmo_expired_c)
    );
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag_d    = tag_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        abort_d  = abort_q;
        buserr_d = buserr_q;
`ifdef CPU_WB_TIMEOUT_EN
        tmo_clear_c = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    state_d  = REQ;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = cpu_we_i;
                    addr_d   = cpu_addr_i;
                    wdata_d  = cpu_wdata_i;
                    tag_d    = '{vp: cpu_vp_i, vpa: cpu_vpa_i, vda: cpu_vda_i};
                    busy_d   = 1'b1;
                    abort_d  = 1'b0;
                    buserr_d = 1'b0;
                end
            end
            REQ: begin
                if (!wb_stall_i) begin
                    state_d = WAIT_ACK;
                    stb_d   = 1'b0;
`ifdef CPU_WB_TIMEOUT_EN
                    tmo_clear_c = 1'b1;
`endif
                end
            end
            WAIT_ACK: begin
                if (access_violation_i) begin
                    abort_d = 1'b1;
                end
                if (wb_ack_i) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = wb_data_i;
                    end
                end
`ifdef CPU_WB_TIMEOUT_EN
                else if (tmo_expired_c) begin
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    rdata_d  = BUS_ERR_DATA;
                    buserr_d = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transaction
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tag_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            abort_q  <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tag_q    <= tag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            abort_q  <= abort_d;
            buserr_q <= buserr_d;
        end
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_strobe_o  = stb_q;
    assign wb_write_o   = we_q;
    assign wb_addr_o    = addr_q;
    assign wb_data_o    = wdata_q;
    assign wb_vp_o      = tag_q.vp;
    assign wb_vpa_o     = tag_q.vpa;
    assign wb_vda_o     = tag_q.vda;
    assign cpu_busy_o   = busy_q;
    assign cpu_done_o   = done_q;
    assign cpu_rdata_o  = rdata_q;
    assign cpu_abort_o  = abort_q;
    assign cpu_buserr_o = buserr_q;

endmodule

// File: tb/tb_cpu_wb_initiator.sv
// Directed self-checking bench for cpu_wb_initiator.
module tb_cpu_wb_initiator;

`ifdef CPU_WB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk;
    logic        wb_reset_i;
    logic        cpu_req_i;
    logic [23:0] cpu_addr_i;
    logic        cpu_we_i;
    logic [7:0]  cpu_wdata_i;
    logic        cpu_vp_i, cpu_vpa_i, cpu_vda_i;
    logic        cpu_busy_o, cpu_done_o, cpu_abort_o, cpu_buserr_o;
    logic [7:0]  cpu_rdata_o;
    logic [23:0] wb_addr_o;
    logic [7:0]  wb_data_o;
    logic        wb_write_o, wb_cyc_o, wb_strobe_o;
    logic [7:0]  wb_data_i;
    logic        wb_ack_i, wb_stall_i;
    logic        wb_vp_o, wb_vpa_o, wb_vda_o;
    logic        access_violation_i;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    cpu_wb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i           (clk),
        .wb_reset_i         (wb_reset_i),
        .cpu_req_i          (cpu_req_i),
        .cpu_addr_i         (cpu_addr_i),
        .cpu_we_i           (cpu_we_i),
        .cpu_wdata_i        (cpu_wdata_i),
        .cpu_vp_i           (cpu_vp_i),
        .cpu_vpa_i          (cpu_vpa_i),
        .cpu_vda_i          (cpu_vda_i),
        .cpu_busy_o         (cpu_busy_o),
        .cpu_done_o         (cpu_done_o),
        .cpu_rdata_o        (cpu_rdata_o),
        .cpu_abort_o        (cpu_abort_o),
        .cpu_buserr_o       (cpu_buserr_o),
        .wb_addr_o          (wb_addr_o),
        .wb_data_o          (wb_data_o),
        .wb_write_o         (wb_write_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_strobe_o        (wb_strobe_o),
        .wb_data_i          (wb_data_i),
        .wb_ack_i           (wb_ack_i),
        .wb_stall_i         (wb_stall_i),
        .wb_vp_o            (wb_vp_o),
        .wb_vpa_o           (wb_vpa_o),
        .wb_vda_o           (wb_vda_o),
        .access_violation_i (access_violation_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU request with a scripted responder; cycle n is n edges after the accept edge
    task automatic txn(input logic [23:0] a, input logic we, input logic [7:0] wd,
                       input int stalls, input int ack_dly, input logic no_ack,
                       input logic [7:0] rd, input int viol_at, input int max_n,
                       output int done_n, output int stb_n, output logic fields_ok,
                       output logic busy_first, output logic busy_done,
                       output logic done_after);
        int st;
        int ack_cnt;
        st = stalls; ack_cnt = 0; done_n = -1; stb_n = 0; fields_ok = 1'b1;
        busy_first = 1'b0; busy_done = 1'b1; done_after = 1'b1;
        cpu_req_i = 1'b1; cpu_addr_i = a; cpu_we_i = we; cpu_wdata_i = wd;
        step();
        cpu_req_i = 1'b0;
        for (int n = 1; n <= max_n; n++) begin
            if (n == 1) busy_first = cpu_busy_o;
            if (cpu_done_o) begin
                done_n = n;
                busy_done = cpu_busy_o;
                break;
            end
            wb_ack_i  = (ack_cnt == 1) && !no_ack;
            wb_data_i = wb_ack_i ? rd : 8'h00;
            if (ack_cnt > 0) ack_cnt--;
            access_violation_i = (n == viol_at);
            wb_stall_i = 1'b0;
            if (wb_strobe_o) begin
                stb_n++;
                if (wb_addr_o !== a || wb_write_o !== we || wb_data_o !== wd || wb_cyc_o !== 1'b1)
                    fields_ok = 1'b0;
                if (st > 0) begin
                    wb_stall_i = 1'b1;
                    st--;
                end else begin
                    ack_cnt = ack_dly + 1;
                end
            end
            if (n < max_n) step();
        end
        wb_ack_i = 1'b0; wb_stall_i = 1'b0; access_violation_i = 1'b0; wb_data_i = 8'h00;
        if (done_n > 0) begin
            step();
            done_after = cpu_done_o;
        end
    endtask

    int   dn, sn;
    logic fok, bf, bd, da;

    initial begin
        wb_reset_i = 1'b1; cpu_req_i = 1'b0; cpu_addr_i = '0; cpu_we_i = 1'b0;
        cpu_wdata_i = '0; cpu_vp_i = 1'b0; cpu_vpa_i = 1'b0; cpu_vda_i = 1'b0;
        wb_data_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0; access_violation_i = 1'b0;
        step(); step();

        // Reset values
        chk("rst_cyc",  32'(wb_cyc_o), 32'h0);
        chk("rst_stb",  32'(wb_strobe_o), 32'h0);
        chk("rst_busy", 32'(cpu_busy_o), 32'h0);
        chk("rst_done", 32'(cpu_done_o), 32'h0);
        chk("rst_bus",  32'({wb_addr_o, wb_data_o}), 32'h0);
        chk("rst_cpu",  32'({cpu_rdata_o, cpu_abort_o, cpu_buserr_o, wb_write_o,
                             wb_vp_o, wb_vpa_o, wb_vda_o}), 32'h0);
        wb_reset_i = 1'b0;
        step();

        // Zero-stall read, one-cycle ack
        txn(24'h001234, 1'b0, 8'h00, 0, 0, 1'b0, 8'hA5, 0, 50, dn, sn, fok, bf, bd, da);
        chk("rd_done_cyc",  32'(dn), 32'd3);
        chk("rd_stb_cycles", 32'(sn), 32'd1);
        chk("rd_fields",    32'(fok), 32'h1);
        chk("rd_busy_req",  32'(bf), 32'h1);
        chk("rd_busy_done", 32'(bd), 32'h0);
        chk("rd_done_pulse", 32'(da), 32'h0);
        chk("rd_rdata",     32'(cpu_rdata_o), 32'hA5);
        chk("rd_abort",     32'(cpu_abort_o), 32'h0);

        // Write with three stall cycles
        txn(24'h010006, 1'b1, 8'h3C, 3, 0, 1'b0, 8'hEE, 0, 50, dn, sn, fok, bf, bd, da);
        chk("wr_done_cyc",  32'(dn), 32'd6);
        chk("wr_stb_cycles", 32'(sn), 32'd4);
        chk("wr_fields",    32'(fok), 32'h1);
        chk("wr_rdata_held", 32'(cpu_rdata_o), 32'hA5);

        // Read with violation pulse early in a 3-cycle ack wait
        txn(24'h000200, 1'b0, 8'h00, 0, 2, 1'b0, 8'h5A, 2, 50, dn, sn, fok, bf, bd, da);
        chk("viol_done_cyc", 32'(dn), 32'd5);
        chk("viol_abort",   32'(cpu_abort_o), 32'h1);
        chk("viol_rdata",   32'(cpu_rdata_o), 32'h5A);

        // Clean read clears abort
        txn(24'h000201, 1'b0, 8'h00, 0, 0, 1'b0, 8'h11, 0, 50, dn, sn, fok, bf, bd, da);
        chk("clean_done_cyc", 32'(dn), 32'd3);
        chk("clean_abort",  32'(cpu_abort_o), 32'h0);
        chk("clean_rdata",  32'(cpu_rdata_o), 32'h11);

`ifdef CPU_WB_TIMEOUT_EN
        // Never acked: four WAIT_ACK cycles then bus error
        txn(24'h000300, 1'b0, 8'h00, 0, 0, 1'b1, 8'h00, 0, 50, dn, sn, fok, bf, bd, da);
        chk("tmo_done_cyc", 32'(dn), 32'd6);
        chk("tmo_rdata",    32'(cpu_rdata_o), 32'hFF);
        chk("tmo_buserr",   32'(cpu_buserr_o), 32'h1);
        txn(24'h000301, 1'b0, 8'h00, 0, 0, 1'b1, 8'h00, 0, 3, dn, sn, fok, bf, bd, da);
        chk("inflight_no_done", 32'(dn), 32'hFFFFFFFF);
`else
        // Never acked: waits indefinitely
        txn(24'h000300, 1'b0, 8'h00, 0, 0, 1'b1, 8'h00, 0, 120, dn, sn, fok, bf, bd, da);
        chk("hang_no_done", 32'(dn), 32'hFFFFFFFF);
        chk("hang_busy",    32'(cpu_busy_o), 32'h1);
        chk("hang_cyc",     32'(wb_cyc_o), 32'h1);
        chk("hang_buserr",  32'(cpu_buserr_o), 32'h0);
`endif

        // Reset while in WAIT_ACK, then a stray ack
        wb_reset_i = 1'b1;
        step();
        chk("mid_rst_cyc",  32'(wb_cyc_o), 32'h0);
        chk("mid_rst_stb",  32'(wb_strobe_o), 32'h0);
        chk("mid_rst_busy", 32'(cpu_busy_o), 32'h0);
        chk("mid_rst_done", 32'(cpu_done_o), 32'h0);
        wb_reset_i = 1'b0;
        wb_ack_i = 1'b1; wb_data_i = 8'h99;
        step();
        wb_ack_i = 1'b0; wb_data_i = 8'h00;
        chk("stray_ack_done", 32'(cpu_done_o), 32'h0);
        chk("stray_ack_cyc",  32'(wb_cyc_o), 32'h0);
        step();
        chk("stray_ack_done2", 32'(cpu_done_o), 32'h0);
        chk("stray_ack_rdata", 32'(cpu_rdata_o), 32'h0);

        // Request held high: one transaction per 4 cycles, tags held with cyc
        begin
            logic ack_nxt;
            logic tag_ok;
            int   cnt, first, last, prev, dones;
            ack_nxt = 1'b0; tag_ok = 1'b1; cnt = 0; first = -1; last = -1; prev = -1; dones = 0;
            cpu_vp_i = 1'b1; cpu_vpa_i = 1'b0; cpu_vda_i = 1'b1;
            cpu_addr_i = 24'h000400; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
            step();
            for (int n = 1; n <= 16; n++) begin
                if (n == 13) cpu_req_i = 1'b0;
                wb_ack_i = ack_nxt; wb_data_i = 8'h77; ack_nxt = 1'b0;
                if (wb_cyc_o && {wb_vp_o, wb_vpa_o, wb_vda_o} !== 3'b101) tag_ok = 1'b0;
                if (cpu_done_o) dones++;
                if (wb_strobe_o) begin
                    cnt++; prev = last; last = n;
                    if (first < 0) first = n;
                    ack_nxt = 1'b1;
                end
                step();
            end
            wb_ack_i = 1'b0;
            chk("b2b_strobes",  32'(cnt), 32'd4);
            chk("b2b_first",    32'(first), 32'd1);
            chk("b2b_spacing",  32'(last - prev), 32'd4);
            chk("b2b_dones",    32'(dones), 32'd4);
            chk("b2b_tags",     32'(tag_ok), 32'h1);
            chk("b2b_idle",     32'({wb_cyc_o, cpu_busy_o}), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_wb_initiator.md
# cpu_wb_initiator

Wishbone initiator that turns single CPU bus requests (65C816 core side) into one-beat pipelined Wishbone transactions toward the MMU and memory/register responders. It carries the CPU cycle-type tags (VP/VPA/VDA) alongside the address. It collects the responder's read data and the MMU's access-violation indication, and returns a completion pulse to the CPU side. An optional watchdog ends transactions that are never acknowledged.

## Interface
- TIMEOUT_CYCLES, 255: cycles without ack, counted after strobe acceptance, before bus error (1..65535).
- wb_clk_i  in  1  Wishbone bus clock; the single clock of the block.
- wb_reset_i  in  1  synchronous, active-high reset.
- cpu_req_i  in  1  request valid; sampled only in IDLE.
- cpu_addr_i  in  24  request address.
- cpu_we_i  in  1  1 = write.
- cpu_wdata_i  in  8  write data.
- cpu_vp_i / cpu_vpa_i / cpu_vda_i  in  1 each  cycle-type tags.
- cpu_busy_o  out  1  high from the accepting edge until done.
- cpu_done_o  out  1  one-cycle completion pulse.
- cpu_rdata_o  out  8  read data; valid while done is high, held until the next done.
- cpu_abort_o  out  1  access violation seen for this transaction; valid with done.
- cpu_buserr_o  out  1  timeout for this transaction; valid with done.
- wb_addr_o  out  24, wb_data_o  out  8, wb_write_o  out  1  request fields.
- wb_cyc_o  out  1, wb_strobe_o  out  1  cycle and strobe.
- wb_data_i  in  8, wb_ack_i  in  1, wb_stall_i  in  1  responder returns.
- wb_vp_o / wb_vpa_o / wb_vda_o  out  1 each  registered tags, held for the whole cycle.
- access_violation_i  in  1  MMU violation flag.

## Operation
- FSM states:
  - IDLE -> REQ on cpu_req_i. Latch addr, we, wdata and tags. Assert busy.
  - REQ: cyc=1, strobe=1. REQ -> WAIT_ACK on the first cycle with wb_stall_i=0; strobe drops on that edge.
  - WAIT_ACK: cyc=1, strobe=0. WAIT_ACK -> DONE on wb_ack_i. Capture wb_data_i for reads; cpu_rdata_o is unchanged for writes.
  - DONE: cyc=0, done=1, busy=0 on the following edge. DONE -> IDLE unconditionally.
- Abort:
  - Latch access_violation_i on any cycle in WAIT_ACK, including the ack cycle.
  - Clear the latch on request accept.
  - Report the latched value as cpu_abort_o during DONE.
  - An abort does not suppress the ack or the data.
- Ignored inputs:
  - wb_ack_i is ignored outside WAIT_ACK.
  - cpu_req_i is ignored outside IDLE; no queueing.
- Outputs are all registered. Reset values: cyc=0, strobe=0, write=0, addr=0, data=0, tags=0, busy=0, done=0, rdata=0, abort=0, buserr=0. FSM resets to IDLE.
- Reset mid-transaction drops cyc/strobe on the same edge and discards the in-flight transaction; no done pulse is produced.

## Timing
- Zero stall with a one-cycle acking responder:
  - req high at edge 0;
  - strobe/cyc high after edge 0;
  - strobe accepted, ack visible after edge 1;
  - done high after edge 2.
  - That is 3 cycles from request to done.
- Each stall cycle adds one cycle; each extra ack-wait cycle adds one cycle.
- A back-to-back request may be sampled in the DONE cycle's following IDLE cycle at the earliest. Minimum spacing between strobes is 4 cycles.

## Configuration
- CPU_WB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_ACK and counts each WAIT_ACK cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop cyc, go to DONE, force cpu_rdata_o=8'hFF, set cpu_buserr_o.
  - Ack in the same cycle as expiry wins: normal completion, buserr=0.
- Not defined: the counter is absent, WAIT_ACK waits indefinitely, and cpu_buserr_o is tied 0.

## Structure
- Package zeus_bus_pkg holds:
  - the state enum typedef (IDLE, REQ, WAIT_ACK, DONE);
  - constant BUS_ERR_DATA = 8'hFF;
  - the tag struct typedef (vp, vpa, vda).
- One sub-module, bus_timeout_counter: inputs clear, enable, hit; output expired. Counter width is $clog2(TIMEOUT_CYCLES+1). It is instantiated only under CPU_WB_TIMEOUT_EN.

## Test plan
- Read at 24'h00_1234, responder acks one cycle after strobe with 8'hA5 -> strobe high for exactly 1 cycle, done 3 cycles after req, cpu_rdata_o=8'hA5, abort=0.
- Write 8'h3C to 24'h01_0006 with wb_stall_i high for 3 cycles -> strobe held 4 cycles with stable addr/data/write, done at cycle 6, cpu_rdata_o unchanged.
- Read with access_violation_i pulsed high one cycle during WAIT_ACK -> cpu_abort_o=1 with done. The next clean read reports abort=0.
- With the macro defined and TIMEOUT_CYCLES=4, no ack ever -> cyc drops after 4 WAIT_ACK cycles, cpu_rdata_o=8'hFF, buserr=1. Without the macro, busy stays high for 100+ cycles.
- Reset asserted in WAIT_ACK -> cyc/strobe/busy=0 next edge, no done pulse. A stray ack afterward is ignored.
- cpu_req_i held high continuously -> exactly one transaction per 4 cycles. Tags vp/vpa/vda=1/0/1 appear on wb_vp_o/wb_vpa_o/wb_vda_o for the whole cycle.
